// File: rtl/axi_skid_receiver_if.sv
// Handshake bundle for the skid receiver: upstream valid/ready/data and downstream valid/ready/data.
interface axi_skid_receiver_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/axi_skid_receiver.sv
// Two-entry skid receiver: output register plus skid register, fully registered
// in_ready/out_valid so neither handshake side has a combinational path to the other.
module axi_skid_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_skid_receiver_if.slave   bus,
  output logic [1:0]           count,
  output logic [CNT_WIDTH-1:0] beats
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [1:0]            count_q;
  logic [CNT_WIDTH-1:0]  beats_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  in_xfer;
  logic                  out_xfer;

  always_comb begin
    in_xfer  = bus.in_valid & in_ready_q;
    out_xfer = out_valid_q & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      beats_q     <= '0;
      out_data_q  <= '0;
      skid_q      <= '0;
    end else begin
      if (in_xfer)
        beats_q <= beats_q + 1'b1;

      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state       <= BUSY;
            out_data_q  <= bus.in_data;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd1;
          end
        end

        BUSY: begin
          // Simultaneous in/out replaces the output beat directly; skid stays unused.
          case ({in_xfer, out_xfer})
            2'b10: begin
              state      <= FULL;
              skid_q     <= bus.in_data;
              in_ready_q <= 1'b0;
              count_q    <= 2'd2;
            end
            2'b01: begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
              count_q     <= 2'd0;
            end
            2'b11: out_data_q <= bus.in_data;
            default: ;
          endcase
        end

        FULL: begin
          if (out_xfer) begin
            state      <= BUSY;
            out_data_q <= skid_q;
            in_ready_q <= 1'b1;
            count_q    <= 2'd1;
          end
        end

        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          count_q     <= 2'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign count         = count_q;
  assign beats         = beats_q;

endmodule

// File: doc/axi_skid_receiver.md
AXI_SKID_RECEIVER -- requirements
Module: axi_skid_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter CNT_WIDTH, default 16, width of the accepted-beat counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_data  input  DATA_WIDTH  upstream payload.
REQ-007 in_ready  output  1  receiver can accept a beat this cycle.
REQ-008 out_valid  output  1  downstream beat valid.
REQ-009 out_data  output  DATA_WIDTH  downstream payload.
REQ-010 out_ready  input  1  downstream consumer accepts the beat.
REQ-011 count  output  2  beats held: 0, 1 or 2.
REQ-012 beats  output  CNT_WIDTH  total input transfers accepted since reset, modulo 2^CNT_WIDTH.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer when out_valid and out_ready are both high.
REQ-014 State machine SHALL have three states: EMPTY (count 0), BUSY (count 1, beat in output register), FULL (count 2, output register plus skid register).
REQ-015 in_ready SHALL be driven from registered state only: high in EMPTY and BUSY, low in FULL; no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL be low in EMPTY, high in BUSY and FULL, driven from registered state only.
REQ-017 EMPTY: input transfer -> BUSY, out_data <= in_data; otherwise stay EMPTY.
REQ-018 BUSY, input only -> FULL, skid <= in_data, out_data unchanged.
REQ-019 BUSY, output only -> EMPTY.
REQ-020 BUSY, simultaneous input and output -> stay BUSY, out_data <= in_data.
REQ-021 BUSY, neither -> stay BUSY, out_data unchanged.
REQ-022 FULL: output transfer -> BUSY, out_data <= skid; otherwise stay FULL; in_valid ignored.
REQ-023 Latency SHALL be one cycle: a beat accepted at edge N is presented with out_valid high after edge N.
REQ-024 Sustained throughput SHALL be one beat per cycle while out_ready held high.
REQ-025 Beats SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-026 out_data SHALL remain stable while out_valid high and out_ready low.
REQ-027 beats SHALL increment by one on each input transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-028 count SHALL equal the number of beats held after each edge, consistent with the state.

Reset
REQ-029 While rst high at an edge: state EMPTY, out_valid 0, in_ready 1 after the edge, count 0, beats 0, out_data and skid 0.
REQ-030 Reset SHALL override any simultaneous transfer; beats held mid-operation are discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Reset, then in_valid=1, in_data=0xA5A5_0001, out_ready=0 for one edge -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1, in_ready=1, beats=1.
REQ-033 out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0, out_data=0x11; third beat 0x33 held on in_valid not accepted, beats=2; out_ready=1 one edge -> out_data=0x22, count=1, in_ready=1.
REQ-034 out_ready=1, in_valid=1 continuously with data 1..8 -> out_data 1..8 on consecutive cycles, count stays 1, in_ready never low.
REQ-035 Random in_valid and out_ready (50%) over 1000 beats -> output sequence equals input sequence, out_data stable under stall, count never exceeds 2.
REQ-036 CNT_WIDTH=4, accept 17 beats -> beats reads 1 after the 17th transfer.
REQ-037 Assert rst while FULL with out_ready=0 -> next cycle out_valid=0, count=0, in_ready=1, beats=0; previous beats never appear on out_data.
